lcd_timing_gen: RTL

- Generates raster timing for the 480x272 RGB LCD panel and produces the x_pos/y_pos pixel coordinates that the snake pixel renderer consumes.
- Provides hsync, vsync and data-enable, delayed so they line up with the renderer's registered colour output.
- Provides a once-per-frame tick in vertical blanking. Game logic uses it to advance snake and apple state.

---
 rtl/lcd_timing_gen.sv | 129 ++++++++++++
 1 files changed

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: raster timing generator for a 480x272 RGB LCD panel.
//
// Two free-running 12-bit counters walk the frame. On each axis the regions
// come in the order sync, back porch, active, front porch. Outside its
// active region each axis coordinate reads 12'hFFF, so the renderer blanks
// without needing any extra qualifier.
//
// Ports:
//   clk        in   1   pixel clock (single clock domain)
//   rst        in   1   asynchronous reset, active-high
//   x_pos      out  12  active column 0..H_DISP-1, 12'hFFF elsewhere
//   y_pos      out  12  active row 0..V_DISP-1, 12'hFFF elsewhere
//   lcd_hs     out  1   horizontal sync, delayed PIPE_DLY clocks
//   lcd_vs     out  1   vertical sync, delayed PIPE_DLY clocks
//   lcd_de     out  1   data enable, delayed PIPE_DLY clocks
//   frame_tick out  1   one-clock pulse at the start of vertical front porch
module lcd_timing_gen #(
   parameter int H_SYNC   = 41,
   parameter int H_BACK   = 2,
   parameter int H_DISP   = 480,
   parameter int H_FRONT  = 2,
   parameter int V_SYNC   = 10,
   parameter int V_BACK   = 2,
   parameter int V_DISP   = 272,
   parameter int V_FRONT  = 2,
   parameter bit SYNC_POL = 1'b0,
   parameter int PIPE_DLY = 1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [11:0] x_pos,
   output logic [11:0] y_pos,
   output logic        lcd_hs,
   output logic        lcd_vs,
   output logic        lcd_de,
   output logic        frame_tick
);

   localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

   localparam logic [11:0] H_LAST      = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST      = 12'(V_TOTAL - 1);
   localparam logic [11:0] H_SYNC_END  = 12'(H_SYNC);
   localparam logic [11:0] V_SYNC_END  = 12'(V_SYNC);
   localparam logic [11:0] H_ACT_START = 12'(H_SYNC + H_BACK);
   localparam logic [11:0] H_ACT_END   = 12'(H_SYNC + H_BACK + H_DISP - 1);
   localparam logic [11:0] V_ACT_START = 12'(V_SYNC + V_BACK);
   localparam logic [11:0] V_ACT_END   = 12'(V_SYNC + V_BACK + V_DISP - 1);
   localparam logic [11:0] V_FP_START  = 12'(V_SYNC + V_BACK + V_DISP);

   // Counters are 12 bits wide and the delay line needs at least one stage.
   if (H_TOTAL > 4095 || V_TOTAL > 4095) begin : g_bad_total
      $error("lcd_timing_gen: H_TOTAL/V_TOTAL exceed the 12-bit counter range");
   end
   if (PIPE_DLY < 1 || PIPE_DLY > 4) begin : g_bad_dly
      $error("lcd_timing_gen: PIPE_DLY must lie in 1..4");
   end

   logic [11:0] h_cnt;
   logic [11:0] v_cnt;
   logic        h_act;
   logic        v_act;
   logic        hs_raw;
   logic        vs_raw;
   logic        de_raw;

   logic [PIPE_DLY-1:0] hs_pipe;
   logic [PIPE_DLY-1:0] vs_pipe;
   logic [PIPE_DLY-1:0] de_pipe;

   // Free-running raster counters; the line counter steps on the pixel wrap,
   // so the last pixel of the last line rolls both to zero on one edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt <= 12'd0;
         v_cnt <= 12'd0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= 12'd0;
         v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
      end else begin
         h_cnt <= h_cnt + 12'd1;
      end
   end

   always_comb begin
      h_act  = (h_cnt >= H_ACT_START) && (h_cnt <= H_ACT_END);
      v_act  = (v_cnt >= V_ACT_START) && (v_cnt <= V_ACT_END);
      x_pos  = h_act ? (h_cnt - H_ACT_START) : 12'hFFF;
      y_pos  = v_act ? (v_cnt - V_ACT_START) : 12'hFFF;
      hs_raw = (h_cnt < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
      vs_raw = (v_cnt < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
      de_raw = h_act && v_act;
   end

   // Delay line aligning the panel strobes with the renderer's registered
   // colour; stage 0 takes the raw value, the last stage drives the pins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hs_pipe <= {PIPE_DLY{~SYNC_POL}};
         vs_pipe <= {PIPE_DLY{~SYNC_POL}};
         de_pipe <= '0;
      end else begin
         hs_pipe[0] <= hs_raw;
         vs_pipe[0] <= vs_raw;
         de_pipe[0] <= de_raw;
         for (int i = 1; i < PIPE_DLY; i++) begin
            hs_pipe[i] <= hs_pipe[i-1];
            vs_pipe[i] <= vs_pipe[i-1];
            de_pipe[i] <= de_pipe[i-1];
         end
      end
   end

   assign lcd_hs = hs_pipe[PIPE_DLY-1];
   assign lcd_vs = vs_pipe[PIPE_DLY-1];
   assign lcd_de = de_pipe[PIPE_DLY-1];

   // Fires the clock after the counters sit at the first front-porch line,
   // pixel 0: game state can advance while nothing is being displayed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= (h_cnt == 12'd0) && (v_cnt == V_FP_START);
      end
   end

endmodule
